// File: rtl/prbs9_checker.sv
// prbs9_checker
// Receive-side checker for a PRBS9 stream (x^9 + x^5 + 1). It locks onto the
// incoming sequence, then counts compared bits and bit errors for BER
// measurement. A burst of errors inside one observation window drops lock.
//
// Ports
//   clock        system clock; all state changes on the rising edge
//   i_reset      asynchronous active-low reset
//   i_bit        received serial bit
//   i_enable     i_bit is valid this cycle; nothing advances while low
//   i_clear      synchronous clear of both counters and the loss window
//   o_locked     checker is in LOCKED
//   o_err        one-cycle pulse: the previous enabled bit mismatched while locked
//   o_bit_count  bits compared while locked (saturating)
//   o_err_count  errors seen while locked (saturating)
//
// state  | meaning
// -------+------------------------------------------------------------------
// SEARCH | loading received bits into the local register, counting matches
// LOCKED | local generator free-runs; received bits are compared and counted

module prbs9_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_bit,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int WIN_W = $clog2(LOSS_WINDOW + 1);

    localparam logic [7:0]       LOCK_C   = 8'(LOCK_COUNT);
    localparam logic [WIN_W-1:0] WINDOW_C = WIN_W'(LOSS_WINDOW);
    localparam logic [WIN_W-1:0] THRESH_C = WIN_W'(LOSS_THRESH);
    localparam logic [3:0]       FULL_C   = 4'd9;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [8:0]         sr_q,      sr_d;
    logic [3:0]         fill_q,    fill_d;
    logic [7:0]         match_q,   match_d;
    logic [WIN_W-1:0]   win_q,     win_d;
    logic [WIN_W-1:0]   errwin_q,  errwin_d;
    logic               err_q,     err_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               pred;
    logic               mis;
    logic [7:0]         match_inc;
    logic [WIN_W-1:0]   win_inc;
    logic [WIN_W-1:0]   errwin_inc;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_q     <= '0;
            errwin_q  <= '0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            errwin_q  <= errwin_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_d      = win_q;
        errwin_d   = errwin_q;
        err_d      = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        err_cnt_d  = err_cnt_q;

        // sr_q[0] is the newest bit, so the next bit is x[n-9] ^ x[n-5]
        pred       = sr_q[8] ^ sr_q[4];
        mis        = i_bit ^ pred;
        match_inc  = match_q + 8'd1;
        win_inc    = win_q + WIN_W'(1);
        errwin_inc = errwin_q + WIN_W'(mis);

        if (i_enable) begin
            unique case (state_q)
                SEARCH: begin
                    sr_d = {sr_q[7:0], i_bit};
                    if (fill_q != FULL_C) begin
                        fill_d = fill_q + 4'd1;
                    end else if (!mis) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d  = LOCKED;
                            win_d    = '0;
                            errwin_d = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // free-running local copy; the received bit is never loaded
                    sr_d  = {sr_q[7:0], pred};
                    err_d = mis;
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (mis && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    // loss of lock outranks a rollover on the same bit
                    if (errwin_inc == THRESH_C) begin
                        state_d  = SEARCH;
                        fill_d   = '0;
                        match_d  = '0;
                        win_d    = win_inc;
                        errwin_d = errwin_inc;
                    end else if (win_inc == WINDOW_C) begin
                        win_d    = '0;
                        errwin_d = '0;
                    end else begin
                        win_d    = win_inc;
                        errwin_d = errwin_inc;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // clear wins over counting the coincident bit; o_err is left alone
        if (i_clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
            win_d     = '0;
            errwin_d  = '0;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_err       = err_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs9_checker.sv
// Testbench for prbs9_checker: directed stimulus from a PRBS9 source (seed
// 'h1AA) with a sequence-level reference model compared on every falling edge.

module tb_prbs9_checker;

    localparam int LOCK_COUNT  = 16;
    localparam int LOSS_WINDOW = 64;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 32;
    localparam int GEN_LEN     = 8192;

    logic             clock;
    logic             i_reset;
    logic             i_bit;
    logic             i_enable;
    logic             i_clear;
    logic             o_locked;
    logic             o_err;
    logic [CNT_W-1:0] o_bit_count;
    logic [CNT_W-1:0] o_err_count;

    prbs9_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_WINDOW(LOSS_WINDOW),
        .LOSS_THRESH(LOSS_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_bit      (i_bit),
        .i_enable   (i_enable),
        .i_clear    (i_clear),
        .o_locked   (o_locked),
        .o_err      (o_err),
        .o_bit_count(o_bit_count),
        .o_err_count(o_err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // stimulus source: x[n] = x[n-9] ^ x[n-5], first nine bits are the seed MSB first
    bit g [GEN_LEN];
    int gi = 0;

    // reference model: the bit history the checker believes, plus its counters
    bit     m_seq[$];
    bit     m_locked = 1'b0;
    bit     m_err    = 1'b0;
    int     m_fill   = 0;
    int     m_match  = 0;
    int     m_win    = 0;
    int     m_errwin = 0;
    longint m_bits   = 0;
    longint m_errs   = 0;
    longint cmax     = (64'd1 << CNT_W) - 1;

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            m_seq.delete();
            for (int k = 0; k < 9; k++) m_seq.push_back(1'b0);
            m_locked = 1'b0;
            m_err    = 1'b0;
            m_fill   = 0;
            m_match  = 0;
            m_win    = 0;
            m_errwin = 0;
            m_bits   = 0;
            m_errs   = 0;
        end else begin
            if (i_enable) begin
                int  n;
                bit  p;
                bit  e;
                n = m_seq.size();
                p = m_seq[n-9] ^ m_seq[n-5];
                e = (i_bit != p);
                if (!m_locked) begin
                    m_err = 1'b0;
                    m_seq.push_back(i_bit);
                    if (m_fill < 9) begin
                        m_fill++;
                    end else if (!e) begin
                        m_match++;
                        if (m_match == LOCK_COUNT) begin
                            m_locked = 1'b1;
                            m_win    = 0;
                            m_errwin = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                end else begin
                    m_err = e;
                    m_seq.push_back(p);
                    if (m_bits < cmax) m_bits++;
                    if (e && m_errs < cmax) m_errs++;
                    m_win++;
                    m_errwin += int'(e);
                    if (m_errwin >= LOSS_THRESH) begin
                        m_locked = 1'b0;
                        m_fill   = 0;
                        m_match  = 0;
                    end else if (m_win == LOSS_WINDOW) begin
                        m_win    = 0;
                        m_errwin = 0;
                    end
                end
                if (m_seq.size() > 32) void'(m_seq.pop_front());
            end else begin
                m_err = 1'b0;
            end
            if (i_clear) begin
                m_bits   = 0;
                m_errs   = 0;
                m_win    = 0;
                m_errwin = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("locked", longint'(o_locked), longint'(m_locked));
        chk("err",    longint'(o_err),    longint'(m_err));
        chk("bitcnt", longint'(o_bit_count), m_bits);
        chk("errcnt", longint'(o_err_count), m_errs);
    end

    task automatic send(input bit b, input bit en, input bit clr);
        i_bit    = b;
        i_enable = en;
        i_clear  = clr;
        @(posedge clock);
        #1;
        i_enable = 1'b0;
        i_clear  = 1'b0;
    endtask

    task automatic stream(input bit flip, input bit en, input bit clr);
        bit b;
        b = en ? (g[gi] ^ flip) : 1'($urandom_range(0, 1));
        if (en) gi++;
        send(b, en, clr);
    endtask

    initial begin
        logic [8:0] seed;
        int ens;
        int cnt;
        bit early;

        seed = 9'h1AA;
        for (int k = 0; k < 9; k++) g[k] = seed[8-k];
        for (int k = 9; k < GEN_LEN; k++) g[k] = g[k-9] ^ g[k-5];

        // pin the source against hand-derived bits
        chk("gen0",  longint'(g[0]),  1);
        chk("gen2",  longint'(g[2]),  0);
        chk("gen9",  longint'(g[9]),  1);
        chk("gen10", longint'(g[10]), 0);
        chk("gen11", longint'(g[11]), 0);
        chk("gen14", longint'(g[14]), 0);

        i_reset  = 1'b0;
        i_bit    = 1'b0;
        i_enable = 1'b0;
        i_clear  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_locked", longint'(o_locked), 0);
        chk("rst_bitcnt", longint'(o_bit_count), 0);
        i_reset = 1'b1;

        // clean stream: lock on the 25th enabled bit
        for (int k = 1; k <= 25; k++) begin
            stream(1'b0, 1'b1, 1'b0);
            if (k == 24) chk("no_lock_24", longint'(o_locked), 0);
            if (k == 25) chk("lock_25",    longint'(o_locked), 1);
        end
        for (int k = 0; k < 1000; k++) stream(1'b0, 1'b1, 1'b0);
        chk("clean_bits", longint'(o_bit_count), 1000);
        chk("clean_errs", longint'(o_err_count), 0);

        // clear while locked and enabled
        stream(1'b0, 1'b1, 1'b1);
        chk("clr_bits",   longint'(o_bit_count), 0);
        chk("clr_errs",   longint'(o_err_count), 0);
        chk("clr_locked", longint'(o_locked), 1);

        // single inverted bit
        stream(1'b1, 1'b1, 1'b0);
        chk("single_err_pulse", longint'(o_err), 1);
        stream(1'b0, 1'b1, 1'b0);
        chk("single_err_gone",  longint'(o_err), 0);
        chk("single_errs",      longint'(o_err_count), 1);
        chk("single_bits",      longint'(o_bit_count), 2);
        chk("single_locked",    longint'(o_locked), 1);

        // 7 errors per window never drops lock
        stream(1'b0, 1'b1, 1'b1);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < LOSS_WINDOW; k++)
                stream(k < 7, 1'b1, 1'b0);
        chk("win7_locked", longint'(o_locked), 1);
        chk("win7_errs",   longint'(o_err_count), 28);
        chk("win7_bits",   longint'(o_bit_count), 256);

        // 8 consecutive errors drop lock, then relock after 25 clean bits
        stream(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            stream(1'b1, 1'b1, 1'b0);
            if (k == 7) chk("burst_still_locked", longint'(o_locked), 1);
            if (k == 8) chk("burst_lost",         longint'(o_locked), 0);
        end
        chk("burst_errs", longint'(o_err_count), 8);
        for (int k = 1; k <= 25; k++) begin
            stream(1'b0, 1'b1, 1'b0);
            if (k == 24) begin
                chk("relock_not_yet", longint'(o_locked), 0);
                chk("search_errs_held", longint'(o_err_count), 8);
            end
            if (k == 25) chk("relock_25", longint'(o_locked), 1);
        end

        // asynchronous reset mid-cycle
        #1;
        i_reset = 1'b0;
        #1;
        chk("async_locked", longint'(o_locked), 0);
        chk("async_err",    longint'(o_err), 0);
        chk("async_bits",   longint'(o_bit_count), 0);
        chk("async_errs",   longint'(o_err_count), 0);
        repeat (2) @(posedge clock);
        #1;
        i_reset = 1'b1;

        // gappy enable on a clean stream
        ens   = 0;
        early = 1'b0;
        for (int c = 0; c < 400 && ens < 25; c++) begin
            bit en;
            en = 1'($urandom_range(0, 1));
            stream(1'b0, en, 1'b0);
            if (en) ens++;
            if (ens < 25 && o_locked) early = 1'b1;
        end
        chk("gap_enables_seen", longint'(ens), 25);
        chk("gap_no_early_lock", longint'(early), 0);
        chk("gap_lock", longint'(o_locked), 1);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            bit en;
            en = 1'($urandom_range(0, 1));
            stream(1'b0, en, 1'b0);
            if (en) cnt++;
        end
        chk("gap_bits", longint'(o_bit_count), longint'(cnt));
        chk("gap_errs", longint'(o_err_count), 0);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Receive-side PRBS9 checker (polynomial x^9 + x^5 + 1) that consumes the serial bit stream produced by the prbs9 generator after the link/channel stage.
- Self-synchronises to the incoming sequence and declares lock.
- While locked, counts compared bits and bit errors for BER measurement, and drops lock on a burst of errors.
- Sits directly downstream of prbs9; its counters are read by the control/register stage.

Parameters:
- LOCK_COUNT, 16, consecutive correct predictions needed to go SEARCH -> LOCKED (1..255)
- LOSS_WINDOW, 64, length in checked bits of the loss-of-lock observation window (2..1024)
- LOSS_THRESH, 8, errors inside one window that force LOCKED -> SEARCH (1..LOSS_WINDOW)
- CNT_W, 32, width of the bit and error counters

Ports:
- clock  in  1  system clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_bit  in  1  received serial bit
- i_enable  in  1  i_bit valid this cycle; nothing advances when low
- i_clear  in  1  synchronous clear of both counters and the window; lock state unaffected
- o_locked  out  1  checker is in LOCKED
- o_err  out  1  one-cycle pulse: the previous enabled bit mismatched while LOCKED
- o_bit_count  out  CNT_W  bits compared while LOCKED, saturating
- o_err_count  out  CNT_W  errors while LOCKED, saturating

Behaviour:
- Reset (i_reset=0, asynchronous): state=SEARCH, internal 9-bit shift register=0, fill/match/window/error-in-window counters=0, o_locked=0, o_err=0, o_bit_count=0, o_err_count=0.
- Prediction: pred = sr[8]^sr[4]. sr[0] holds the newest bit.
- i_enable=0: every register holds, and o_err=0.
- SEARCH, each enabled cycle:
  - Shift the received bit in: sr <= {sr[7:0], i_bit}.
  - fill counter increments, saturating at 9.
  - While fill<9, no comparison is made.
  - Once fill=9: if i_bit==pred, match++; otherwise match=0.
  - When match reaches LOCK_COUNT, on that same edge: state=LOCKED, window and error-in-window counters cleared.
  - No counting and no o_err while in SEARCH.
- LOCKED, each enabled cycle:
  - The local generator free-runs: sr <= {sr[7:0], pred}. The received bit is never loaded.
  - err = (i_bit != pred).
  - o_bit_count++ and, if err, o_err_count++. Both saturate at all ones; the error count saturates independently of the bit count.
  - o_err is registered and equals err one cycle later.
  - The window counter increments per enabled bit. errwin increments on each err.
  - If errwin (including the current error) reaches LOSS_THRESH: state=SEARCH, fill=0, match=0. sr keeps its contents; the counters keep their values.
  - Otherwise, when the window reaches LOSS_WINDOW, window and errwin both clear to 0.
- o_locked is a registered copy of the state. Latency: o_locked rises on the clock edge of the enabled bit that completes LOCK_COUNT matches.
- i_clear=1 on an edge: o_bit_count, o_err_count, window and errwin go to 0.
  - If i_clear coincides with an enabled locked bit, the clear wins: counters=0 and that bit is not counted.
  - o_err still reflects that bit.
- Loss of lock takes priority over a window rollover on the same bit.
- Reset asserted mid-operation returns everything immediately to the reset values.

Test Plan:
- Feed prbs9 (SEED 'h1AA, first bits 1,1,0,1,0,1,0,1,0,...) with i_enable=1 continuously.
  - Required: o_locked rises on the edge of enabled bit 25 (9 fill + 16 matches).
  - o_bit_count increments 1/cycle from then on; o_err_count stays 0 over 1000 bits.
- After lock, invert a single bit.
  - Required: exactly one o_err pulse, one cycle after that bit; o_err_count=1; o_locked stays 1.
- After lock, invert 8 consecutive bits.
  - Required: o_locked falls on the 8th error.
  - Relock follows 25 enabled clean bits later; o_err_count=8 is held through SEARCH.
- Inject 7 errors per 64-bit window, repeatedly.
  - Required: lock is never lost, because each window rollover clears errwin; o_err_count grows by 7 per window.
- Toggle i_enable with a random ~50% duty on a clean stream.
  - Required: lock occurs after 25 enabled bits regardless of gaps; no errors; o_bit_count equals the number of enabled locked bits.
- Pulse i_clear with i_enable=1 while locked; separately assert i_reset=0 asynchronously mid-stream.
  - i_clear required: counters read 0 on the next cycle, and o_locked is unaffected.
  - i_reset required: all outputs reach 0 immediately, before the next clock edge.
